packet_arbiter_rr: RTL and testbench

PACKET_ARBITER_RR -- requirements
Module: packet_arbiter_rr

---
 rtl/packet_arbiter_rr.sv | 164 ++++++++++++++++
 tb/tb_packet_arbiter_rr.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_arbiter_rr.sv
// Round-robin packet arbiter: grants one AXI-Stream input and holds it until TLAST transfers.
// Define ARB_OUTPUT_REG_EN to drive out_mosi_o from a 2-entry skid buffer.

package packet_arbiter_rr_pkg;
  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_ID_W   = 4;

  localparam logic [AXIS_ID_W-1:0] ROUTING_HEADER = AXIS_ID_W'(4'hF);

  typedef struct packed {
    logic                   tvalid;
    logic                   tlast;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;
endpackage

module packet_arbiter_rr
  import packet_arbiter_rr_pkg::*;
#(
  parameter int unsigned CHANNEL_NUMBER       = 5,
  parameter int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  axis_mosi_t                      in_mosi_i [CHANNEL_NUMBER],
  output axis_miso_t                      in_miso_o [CHANNEL_NUMBER],
  output axis_mosi_t                      out_mosi_o,
  input  axis_miso_t                      out_miso_i,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] grant_o,
  output logic                            locked_o
);

  localparam int unsigned W = CHANNEL_NUMBER_WIDTH;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   grant_q, grant_d;
  logic [W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   sel_idx_c;
  logic           sel_found_c;
  logic           last_xfer_c;

  // (base + off) mod CHANNEL_NUMBER; both operands are already below CHANNEL_NUMBER.
  function automatic logic [W-1:0] wrap_idx(input logic [W-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= CHANNEL_NUMBER) s = s - CHANNEL_NUMBER;
    return W'(s);
  endfunction

  // First valid input searching upward from rr_ptr.
  always_comb begin
    sel_idx_c   = '0;
    sel_found_c = 1'b0;
    for (int unsigned k = 0; k < CHANNEL_NUMBER; k++) begin
      if (!sel_found_c && in_mosi_i[wrap_idx(rr_ptr_q, k)].tvalid) begin
        sel_found_c = 1'b1;
        sel_idx_c   = wrap_idx(rr_ptr_q, k);
      end
    end
  end

`ifdef ARB_OUTPUT_REG_EN
  axis_mosi_t buf_q [2];
  axis_mosi_t buf_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic       full_c;
  logic       push_c;
  logic       pop_c;

  assign full_c      = (cnt_q == 2'd2);
  assign push_c      = (state_q == LOCKED) && in_mosi_i[grant_q].tvalid && !full_c;
  assign pop_c       = (cnt_q != 2'd0) && out_miso_i.tready;
  // The packet is done for the arbiter once its TLAST is held in the buffer.
  assign last_xfer_c = push_c && in_mosi_i[grant_q].tlast;

  always_comb begin
    buf_d = buf_q;
    if (push_c) buf_d[wr_q] = in_mosi_i[grant_q];
    wr_d  = wr_q ^ push_c;
    rd_d  = rd_q ^ pop_c;
    cnt_d = cnt_q + 2'(push_c) - 2'(pop_c);
  end
`else
  assign last_xfer_c = (state_q == LOCKED) && in_mosi_i[grant_q].tvalid &&
                       in_mosi_i[grant_q].tlast && out_miso_i.tready;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
`ifdef ARB_OUTPUT_REG_EN
      buf_q    <= '{default: '0};
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef ARB_OUTPUT_REG_EN
      buf_q    <= buf_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next state: grant on any valid input, release on the TLAST transfer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found_c) begin
          state_d = LOCKED;
          grant_d = sel_idx_c;
        end
      end
      LOCKED: begin
        if (last_xfer_c) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_idx(grant_q, 1);
        end
      end
    endcase
  end

  // Outputs: route the granted input, everything else held at zero.
  always_comb begin
    in_miso_o  = '{default: '0};
    out_mosi_o = '0;
    grant_o    = grant_q;
    locked_o   = (state_q == LOCKED);
`ifdef ARB_OUTPUT_REG_EN
    if (cnt_q != 2'd0) out_mosi_o = buf_q[rd_q];
    if (state_q == LOCKED) in_miso_o[grant_q].tready = !full_c;
`else
    if (state_q == LOCKED) begin
      out_mosi_o         = in_mosi_i[grant_q];
      in_miso_o[grant_q] = out_miso_i;
    end
`endif
  end

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// Bench for packet_arbiter_rr: random packet traffic checked against a queue-level round-robin model.
// Compile with ARB_OUTPUT_REG_EN defined to also exercise the skid-buffer build.

module tb_packet_arbiter_rr;
  import packet_arbiter_rr_pkg::*;

  localparam int N = 5;
  localparam int W = 3;
`ifdef ARB_OUTPUT_REG_EN
  localparam int FIRST_OUT = 2;
`else
  localparam int FIRST_OUT = 1;
`endif

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  axis_mosi_t   in_mosi [N];
  axis_miso_t   in_miso [N];
  axis_mosi_t   out_mosi;
  axis_miso_t   out_miso;
  logic [W-1:0] grant;
  logic         locked;

  packet_arbiter_rr #(
    .CHANNEL_NUMBER       (N),
    .CHANNEL_NUMBER_WIDTH (W)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_mosi_i  (in_mosi),
    .in_miso_o  (in_miso),
    .out_mosi_o (out_mosi),
    .out_miso_i (out_miso),
    .grant_o    (grant),
    .locked_o   (locked)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  axis_mosi_t src_q [N][$];
  axis_mosi_t exp_q [$];
  int         exp_g [$];
  int         model_ptr;

  axis_mosi_t obs_q [$];
  int         obs_cyc [$];
  int         obs_g [$];
  int         lock_cyc [$];
  bit         lock_hist [$];
  int         cyc, bad_rdy, tlast_acc_cyc, first_acc_cyc, first_outv_cyc;
  bit         prev_locked;

  int         rdy_mode;
  bit [63:0]  rdy_pat;
  int         hold_in, hold_from, hold_len;

  task automatic add_pkt(input int ch, input int len);
    axis_mosi_t fl;
    for (int f = 0; f < len; f++) begin
      fl.tvalid = 1'b1;
      fl.tlast  = (f == len - 1);
      fl.tid    = (f == 0 || ($urandom % 3) == 0) ? ROUTING_HEADER : AXIS_ID_W'($urandom);
      fl.tdata  = $urandom;
      src_q[ch].push_back(fl);
    end
  endtask

  // Reference: whole packets leave in round-robin order starting at model_ptr.
  task automatic build_model();
    axis_mosi_t cp [N][$];
    axis_mosi_t f;
    int g;
    for (int i = 0; i < N; i++) cp[i] = src_q[i];
    exp_q.delete();
    exp_g.delete();
    for (int p = 0; p < 64; p++) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && cp[(model_ptr + k) % N].size() > 0) g = (model_ptr + k) % N;
      if (g < 0) break;
      exp_g.push_back(g);
      do begin
        f = cp[g].pop_front();
        exp_q.push_back(f);
      end while (!f.tlast);
      model_ptr = (g + 1) % N;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_cyc.delete(); obs_g.delete(); lock_cyc.delete(); lock_hist.delete();
    cyc = 0; bad_rdy = 0; tlast_acc_cyc = -1; first_acc_cyc = -1; first_outv_cyc = -1;
    prev_locked = locked;
  endtask

  task automatic step();
    bit acc [N];
    axis_mosi_t f;
    @(negedge clk_i);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !(i == hold_in && cyc >= hold_from && cyc < hold_from + hold_len))
        in_mosi[i] = src_q[i][0];
      else
        in_mosi[i] = '0;
    end
    case (rdy_mode)
      0:       out_miso.tready = 1'b1;
      1:       out_miso.tready = (($urandom % 4) != 0);
      default: out_miso.tready = rdy_pat[cyc % 64];
    endcase
    #1;
    for (int i = 0; i < N; i++) begin
      acc[i] = in_mosi[i].tvalid && in_miso[i].tready;
`ifdef ARB_OUTPUT_REG_EN
      if (in_miso[i].tready && (!locked || int'(grant) != i)) bad_rdy++;
`else
      if (in_miso[i].tready && (!locked || int'(grant) != i || !out_miso.tready)) bad_rdy++;
`endif
    end
`ifndef ARB_OUTPUT_REG_EN
    if (!locked && out_mosi !== '0) bad_rdy++;
`endif
    if (locked && !prev_locked) begin
      lock_cyc.push_back(cyc);
      obs_g.push_back(int'(grant));
    end
    prev_locked = locked;
    lock_hist.push_back(locked);
    if (out_mosi.tvalid && first_outv_cyc < 0) first_outv_cyc = cyc;
    if (out_mosi.tvalid && out_miso.tready) begin
      obs_q.push_back(out_mosi);
      obs_cyc.push_back(cyc);
    end
    @(posedge clk_i);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        f = src_q[i].pop_front();
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        if (f.tlast) tlast_acc_cyc = cyc;
      end
    end
    cyc++;
  endtask

  task automatic run_traffic(input int max_cyc, input int stop_xfers, output bit done);
    bit empty;
    clear_obs();
    done = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (stop_xfers > 0) begin
        if (obs_q.size() >= stop_xfers) begin done = 1'b1; break; end
      end else begin
        empty = 1'b1;
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) empty = 1'b0;
        if (empty && obs_q.size() >= exp_q.size()) begin done = 1'b1; break; end
      end
    end
    if (done && stop_xfers == 0) begin step(); step(); end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    for (int i = 0; i < N; i++) begin in_mosi[i] = '0; src_q[i].delete(); end
    @(negedge clk_i);
    rst_n_i   = 1'b1;
    model_ptr = 0;
  endtask

  task automatic test_reset();
    int nz;
    for (int i = 0; i < N; i++) begin
      in_mosi[i]        = '0;
      in_mosi[i].tvalid = 1'b1;
      in_mosi[i].tdata  = $urandom;
    end
    out_miso.tready = 1'b1;
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    nz = 0;
    for (int i = 0; i < N; i++) if (in_miso[i] !== '0) nz++;
    n_tests++; if (out_mosi !== '0) begin n_fail++; $display("FAIL reset_out_mosi: got %h want 0", out_mosi); end
    n_tests++; if (nz != 0) begin n_fail++; $display("FAIL reset_in_miso: %0d inputs ready, want 0", nz); end
    n_tests++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", locked); end
    do_reset();
  endtask

  task automatic test_single_input();
    bit ok, bad;
    int g0, g1, lc;
    add_pkt(2, 3);
    build_model();
    rdy_mode = 0;
    run_traffic(40, 0, ok);
    g0 = (obs_g.size() > 0) ? obs_g[0] : -1;
    lc = (lock_cyc.size() > 0) ? lock_cyc[0] : -1;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d flits want %0d", obs_q.size(), exp_q.size()); end
    n_tests++; if (g0 != 2) begin n_fail++; $display("FAIL single_grant: got %0d want 2", g0); end
    n_tests++; if (lc != 1) begin n_fail++; $display("FAIL single_bubble: lock at cycle %0d want 1", lc); end
    bad = (obs_q.size() != 3);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL single_stream: got %0d flits want 3 matching", obs_q.size()); end
    n_tests++;
    if (obs_cyc.size() != 3 || obs_cyc[0] != FIRST_OUT || obs_cyc[2] != FIRST_OUT + 2) begin
      n_fail++;
      $display("FAIL single_consecutive: first %0d last %0d want %0d..%0d",
               (obs_cyc.size() > 0) ? obs_cyc[0] : -1, (obs_cyc.size() > 2) ? obs_cyc[2] : -1,
               FIRST_OUT, FIRST_OUT + 2);
    end
    // Pointer now sits at 3, so input 3 beats input 1.
    add_pkt(1, 1);
    add_pkt(3, 1);
    build_model();
    run_traffic(40, 0, ok);
    g0 = (obs_g.size() > 0) ? obs_g[0] : -1;
    g1 = (obs_g.size() > 1) ? obs_g[1] : -1;
    n_tests++; if (!ok || g0 != 3 || g1 != 1) begin n_fail++; $display("FAIL single_rr_ptr: got %0d,%0d want 3,1", g0, g1); end
  endtask

  task automatic test_rr_order();
    bit ok, bad;
    int want [6] = '{0, 1, 4, 0, 1, 4};
    do_reset();
    for (int p = 0; p < 2; p++) begin add_pkt(0, 2); add_pkt(1, 2); add_pkt(4, 2); end
    build_model();
    rdy_mode = 1;
    run_traffic(200, 0, ok);
    bad = !ok || (obs_g.size() != 6);
    for (int i = 0; i < 6 && i < obs_g.size(); i++) if (obs_g[i] != want[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL rr_order: got %0d grants first %0d want 0,1,4,0,1,4", obs_g.size(), (obs_g.size() > 0) ? obs_g[0] : -1); end
    bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL rr_stream: got %0d flits want %0d matching", obs_q.size(), exp_q.size()); end
    n_tests++; if (bad_rdy != 0) begin n_fail++; $display("FAIL rr_isolation: got %0d stray cycles want 0", bad_rdy); end
  endtask

  task automatic test_wrap();
    bit ok;
    int g0, g1;
    add_pkt(3, 1);
    build_model();
    rdy_mode = 0;
    run_traffic(40, 0, ok);
    add_pkt(4, 2);
    add_pkt(0, 2);
    build_model();
    run_traffic(60, 0, ok);
    g0 = (obs_g.size() > 0) ? obs_g[0] : -1;
    g1 = (obs_g.size() > 1) ? obs_g[1] : -1;
    n_tests++; if (!ok || g0 != 4 || g1 != 0) begin n_fail++; $display("FAIL wrap_order: got %0d,%0d want 4,0", g0, g1); end
  endtask

  task automatic test_backpressure();
    bit ok, bad, held;
    add_pkt(1, 4);
    add_pkt(3, 2);
    build_model();
    rdy_mode = 2;
    rdy_pat  = ~(64'h1F << 3);
    run_traffic(80, 0, ok);
    bad = !ok || (obs_q.size() != exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL bp_stream: got %0d flits want %0d exact", obs_q.size(), exp_q.size()); end
    n_tests++; if (obs_g.size() != 2 || obs_g[0] != exp_g[0] || obs_g[1] != exp_g[1]) begin n_fail++; $display("FAIL bp_grants: got %0d first %0d want 1", obs_g.size(), (obs_g.size() > 0) ? obs_g[0] : -1); end
    held = (lock_hist.size() > 7);
    for (int c = 3; c <= 7 && c < lock_hist.size(); c++) if (!lock_hist[c]) held = 1'b0;
    n_tests++; if (!held) begin n_fail++; $display("FAIL bp_lock_held: lock dropped in stall, want held"); end
    n_tests++; if (bad_rdy != 0) begin n_fail++; $display("FAIL bp_isolation: got %0d stray cycles want 0", bad_rdy); end
    rdy_mode = 0;
  endtask

  task automatic test_single_flit();
    bit ok;
    add_pkt(2, 1);
    build_model();
    rdy_mode = 0;
    run_traffic(20, 0, ok);
    n_tests++;
    if (!ok || obs_cyc.size() != 1 || obs_cyc[0] != FIRST_OUT || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL single_flit: got %0d flits at %0d want 1 at %0d", obs_q.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, FIRST_OUT);
    end
    n_tests++; if (lock_hist.size() < 3 || lock_hist[1] != 1'b1 || lock_hist[2] != 1'b0) begin n_fail++; $display("FAIL single_flit_release: lock trace wrong, want 0,1,0"); end
  endtask

  task automatic test_drop_valid();
    bit ok, bad, held;
    axis_mosi_t t;
    add_pkt(0, 4);
    add_pkt(2, 2);
    t = src_q[0][1];
    t.tid = ROUTING_HEADER;
    src_q[0][1] = t;
    build_model();
    rdy_mode  = 0;
    hold_in   = 0;
    hold_from = 3;
    hold_len  = 4;
    run_traffic(80, 0, ok);
    hold_in = -1;
    bad = !ok || (obs_q.size() != exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL drop_stream: got %0d flits want %0d exact", obs_q.size(), exp_q.size()); end
    n_tests++; if (obs_q.size() < 2 || obs_q[1].tid !== ROUTING_HEADER || obs_q[1].tlast !== 1'b0) begin n_fail++; $display("FAIL mid_header: header flit not forwarded as mid-packet"); end
    n_tests++; if (obs_g.size() != 2 || obs_g[0] != exp_g[0] || obs_g[1] != exp_g[1]) begin n_fail++; $display("FAIL drop_grants: got %0d first %0d want 0", obs_g.size(), (obs_g.size() > 0) ? obs_g[0] : -1); end
    held = (lock_hist.size() > 6);
    for (int c = 3; c <= 6 && c < lock_hist.size(); c++) if (!lock_hist[c]) held = 1'b0;
    n_tests++; if (!held || bad_rdy != 0) begin n_fail++; $display("FAIL drop_lock_held: held=%0b stray=%0d want 1,0", held, bad_rdy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nz, g0;
    add_pkt(3, 1);
    build_model();
    rdy_mode = 0;
    run_traffic(20, 0, ok);
    add_pkt(3, 4);
    run_traffic(20, 1, ok);
    @(negedge clk_i);
    in_mosi[3]      = src_q[3][0];
    out_miso.tready = 1'b1;
    #1;
    n_tests++; if (!ok || locked !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: locked=%0b want 1", locked); end
`ifndef ARB_OUTPUT_REG_EN
    n_tests++; if (out_mosi !== src_q[3][0]) begin n_fail++; $display("FAIL rstmid_flit2: got %h want %h", out_mosi, src_q[3][0]); end
`endif
    rst_n_i = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < N; i++) if (in_miso[i] !== '0) nz++;
    n_tests++;
    if (out_mosi !== '0 || nz != 0 || grant !== '0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_zero: out=%h ready=%0d grant=%0d locked=%0b want all 0", out_mosi, nz, grant, locked);
    end
    for (int i = 0; i < N; i++) begin in_mosi[i] = '0; src_q[i].delete(); end
    @(negedge clk_i);
    rst_n_i   = 1'b1;
    model_ptr = 0;
    add_pkt(1, 1);
    add_pkt(4, 1);
    build_model();
    run_traffic(40, 0, ok);
    g0 = (obs_g.size() > 0) ? obs_g[0] : -1;
    n_tests++; if (!ok || g0 != 1) begin n_fail++; $display("FAIL rstmid_restart: got grant %0d want 1", g0); end
  endtask

`ifdef ARB_OUTPUT_REG_EN
  task automatic test_outreg();
    bit ok, bad;
    add_pkt(int'($urandom_range(0, N - 1)), 8);
    build_model();
    rdy_mode = 1;
    run_traffic(200, 0, ok);
    bad = !ok || (obs_q.size() != 8);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    n_tests++; if (bad) begin n_fail++; $display("FAIL outreg_stream: got %0d flits want 8 exact", obs_q.size()); end
    n_tests++; if (first_outv_cyc != first_acc_cyc + 1) begin n_fail++; $display("FAIL outreg_latency: out at %0d want %0d", first_outv_cyc, first_acc_cyc + 1); end
    n_tests++;
    if (tlast_acc_cyc < 0 || lock_hist.size() <= tlast_acc_cyc + 1 ||
        lock_hist[tlast_acc_cyc] != 1'b1 || lock_hist[tlast_acc_cyc + 1] != 1'b0) begin
      n_fail++;
      $display("FAIL outreg_release: tlast accepted at %0d, lock not released next cycle", tlast_acc_cyc);
    end
    n_tests++; if (bad_rdy != 0) begin n_fail++; $display("FAIL outreg_isolation: got %0d stray cycles want 0", bad_rdy); end
  endtask
`endif

  initial begin
    rst_n_i         = 1'b0;
    out_miso.tready = 1'b0;
    for (int i = 0; i < N; i++) in_mosi[i] = '0;
    hold_in   = -1;
    hold_from = 0;
    hold_len  = 0;
    rdy_mode  = 0;
    rdy_pat   = '1;
    model_ptr = 0;
    test_reset();
    test_single_input();
    test_rr_order();
    test_wrap();
    test_backpressure();
    test_single_flit();
    test_drop_valid();
    test_reset_mid();
`ifdef ARB_OUTPUT_REG_EN
    test_outreg();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
